// File: rtl/melody_pkg.sv
// Shared types and constants for the melody recorder/player: controller states,
// the (note, octave) key, and the stored-entry field layout.
package melody_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REC       = 2'd1,
      ST_PLAY_LOAD = 2'd2,
      ST_PLAY      = 2'd3
   } state_t;

   localparam int NOTE_W = 4;
   localparam int OCT_W  = 4;
   localparam int KEY_W  = NOTE_W + OCT_W;

   localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

   // A stored entry is {key, duration}; the key occupies the top KEY_W bits.
   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [OCT_W-1:0]  octave;
   } key_t;

   function automatic int entry_w(input int dw);
      return KEY_W + dw;
   endfunction

endpackage

// File: rtl/melody_ram.sv
// Single-port synchronous RAM holding recorded melody entries; read data is
// registered, so a read issued at one edge is usable during the next cycle.
module melody_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int W     = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // NOTE: no reset here -- RAM arrays cannot be reset in a single cycle and
   // the controller never reads an entry it has not written since count cleared.
   // NOTE: non-blocking assignments keep read-before-write ordering well defined.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/melody_sequencer.sv
// Records keypad notes with tick-based durations into melody_ram and plays
// them back, arbitrating the pitch generator input (live keypad always wins).
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int TICK_CYCLES = 1000000,
   parameter int DEPTH       = 64,
   parameter int AW          = 6,
   parameter int DW          = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    live_note,
   input  logic [3:0]    live_octave,
   input  logic          rec_start,
   input  logic          play_start,
   input  logic          stop,
   input  logic          loop,
   output logic [3:0]    note,
   output logic [3:0]    octave,
   output logic [1:0]    state,
   output logic [AW:0]   count,
   output logic          full,
   output logic          done
);

   localparam int EW = entry_w(DW);
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [DW-1:0] DUR_MAX = {DW{1'b1}};

   state_t        st, st_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic [DW-1:0] dur, dur_nxt, dur_inc, rem, rem_nxt, wdur;
   logic [AW-1:0] addr, addr_nxt, ram_addr;
   logic [AW:0]   count_nxt;
   logic          full_nxt, done_nxt, tick, we;
   key_t          live, cur, cur_nxt, out_key, out_nxt, stored, wkey;
   logic [EW-1:0] wdata, rdata;

   assign live    = '{note: live_note, octave: live_octave};
   assign stored  = key_t'(rdata[EW-1:DW]);
   assign tick    = (st == ST_REC || st == ST_PLAY) && (tcnt == TW'(TICK_CYCLES - 1));
   // A tick landing in the same cycle as a key change counts toward the old key.
   assign dur_inc = dur + DW'(tick);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      st_nxt    = st;
      tcnt_nxt  = tcnt;
      dur_nxt   = dur;
      rem_nxt   = rem;
      addr_nxt  = addr;
      count_nxt = count;
      full_nxt  = full;
      done_nxt  = 1'b0;
      cur_nxt   = cur;
      out_nxt   = out_key;
      we        = 1'b0;
      wkey      = cur;
      wdur      = dur_inc;

      if (st == ST_REC || st == ST_PLAY) tcnt_nxt = tick ? '0 : tcnt + 1'b1;

      unique case (st)
         ST_IDLE: begin
            out_nxt = live;
            if (!stop && rec_start) begin
               st_nxt    = ST_REC;
               count_nxt = '0;
               full_nxt  = 1'b0;
               cur_nxt   = live;
               dur_nxt   = '0;
               tcnt_nxt  = '0;
            end else if (!stop && play_start && count != '0) begin
               st_nxt   = ST_PLAY_LOAD;
               addr_nxt = '0;
               tcnt_nxt = '0;
            end
         end

         ST_REC: begin
            out_nxt = live;
            if (stop) begin
               we     = (dur_inc != '0);
               st_nxt = ST_IDLE;
            end else if (live != cur) begin
               we      = 1'b1;
               wdur    = (dur_inc == '0) ? DW'(1) : dur_inc;
               cur_nxt = live;
               dur_nxt = '0;
            end else if (dur_inc == DUR_MAX) begin
               we      = 1'b1;
               dur_nxt = '0;
            end else begin
               dur_nxt = dur_inc;
            end
            if (we) begin
               count_nxt = count + 1'b1;
               if (count_nxt == (AW+1)'(DEPTH)) begin
                  full_nxt = 1'b1;
                  st_nxt   = ST_IDLE;
               end
            end
         end

         ST_PLAY_LOAD: begin
            if (stop) begin
               st_nxt = ST_IDLE;
            end else begin
               st_nxt  = ST_PLAY;
               rem_nxt = rdata[DW-1:0];
            end
         end

         ST_PLAY: begin
            out_nxt = (live_note != NOTE_REST) ? live : stored;
            if (stop) begin
               st_nxt = ST_IDLE;
            end else if (tick) begin
               if (rem == DW'(1)) begin
                  tcnt_nxt = '0;
                  if ({1'b0, addr} + 1'b1 == count) begin
                     if (loop) begin
                        addr_nxt = '0;
                        st_nxt   = ST_PLAY_LOAD;
                     end else begin
                        st_nxt   = ST_IDLE;
                        done_nxt = 1'b1;
                     end
                  end else begin
                     addr_nxt = addr + 1'b1;
                     st_nxt   = ST_PLAY_LOAD;
                  end
               end else begin
                  rem_nxt = rem - 1'b1;
               end
            end
         end
      endcase

      // Writes go to the next free slot; otherwise pre-read the next playback address.
      ram_addr = we ? count[AW-1:0] : addr_nxt;
      wdata    = {wkey, wdur};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= ST_IDLE;
         tcnt    <= '0;
         dur     <= '0;
         rem     <= '0;
         addr    <= '0;
         count   <= '0;
         full    <= 1'b0;
         done    <= 1'b0;
         cur     <= '0;
         out_key <= '0;
      end else begin
         st      <= st_nxt;
         tcnt    <= tcnt_nxt;
         dur     <= dur_nxt;
         rem     <= rem_nxt;
         addr    <= addr_nxt;
         count   <= count_nxt;
         full    <= full_nxt;
         done    <= done_nxt;
         cur     <= cur_nxt;
         out_key <= out_nxt;
      end
   end

   melody_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (EW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .addr  (ram_addr),
      .wdata (wdata),
      .rdata (rdata)
   );

   assign note   = out_key.note;
   assign octave = out_key.octave;
   assign state  = st;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench: directed scenarios plus randomized commands, all compared
// every cycle against an event-level model of recording and playback.
module tb_melody_sequencer;

   localparam int TICK    = 4;
   localparam int DEPTH   = 64;
   localparam int AW      = 6;
   localparam int DW      = 8;
   localparam int S_DEPTH = 4;
   localparam int S_AW    = 2;
   localparam int DMAX    = (1 << DW) - 1;

   localparam int M_IDLE = 0, M_REC = 1, M_LOAD = 2, M_PLAY = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  live_note, live_octave, note, octave;
   logic        rec_start, play_start, stop, loop, full, done;
   logic [1:0]  state;
   logic [AW:0] count;

   logic [3:0]    s_live_note, s_live_octave, s_note, s_octave;
   logic          s_rec_start, s_play_start, s_stop, s_loop, s_full, s_done;
   logic [1:0]    s_state;
   logic [S_AW:0] s_count;

   melody_sequencer #(.TICK_CYCLES(TICK), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .live_note(live_note), .live_octave(live_octave),
      .rec_start(rec_start), .play_start(play_start), .stop(stop), .loop(loop),
      .note(note), .octave(octave), .state(state), .count(count), .full(full), .done(done)
   );

   melody_sequencer #(.TICK_CYCLES(TICK), .DEPTH(S_DEPTH), .AW(S_AW), .DW(DW)) dut_small (
      .clk(clk), .rst_n(rst_n), .live_note(s_live_note), .live_octave(s_live_octave),
      .rec_start(s_rec_start), .play_start(s_play_start), .stop(s_stop), .loop(s_loop),
      .note(s_note), .octave(s_octave), .state(s_state), .count(s_count), .full(s_full),
      .done(s_done)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the recording is a list of (note, octave, duration) entries.
   int m_mode, m_tcnt, m_cnt, m_idx, m_rem, m_dur, m_note, m_oct, m_cur_n, m_cur_o;
   bit m_full, m_done;
   int mem_n[DEPTH], mem_o[DEPTH], mem_d[DEPTH];

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = M_IDLE; m_tcnt = 0; m_cnt = 0; m_idx = 0; m_rem = 0; m_dur = 0;
      m_note = 0; m_oct = 0; m_cur_n = 0; m_cur_o = 0; m_full = 0; m_done = 0;
   endfunction

   function automatic void store(input int n, input int o, input int d);
      mem_n[m_cnt] = n; mem_o[m_cnt] = o; mem_d[m_cnt] = d;
      m_cnt++;
      if (m_cnt == DEPTH) begin
         m_full = 1;
         m_mode = M_IDLE;
      end
   endfunction

   task automatic model_step();
      bit tick;
      int d;
      int ln = int'(live_note);
      int lo = int'(live_octave);
      tick = (m_mode == M_REC || m_mode == M_PLAY) && (m_tcnt == TICK - 1);
      if (m_mode == M_REC || m_mode == M_PLAY) m_tcnt = tick ? 0 : m_tcnt + 1;
      m_done = 0;
      case (m_mode)
         M_IDLE: begin
            m_note = ln; m_oct = lo;
            if (!stop && rec_start) begin
               m_mode = M_REC; m_cnt = 0; m_full = 0;
               m_cur_n = ln; m_cur_o = lo; m_dur = 0; m_tcnt = 0;
            end else if (!stop && play_start && m_cnt > 0) begin
               m_mode = M_LOAD; m_idx = 0; m_tcnt = 0;
            end
         end
         M_REC: begin
            m_note = ln; m_oct = lo;
            d = m_dur + int'(tick);
            if (stop) begin
               m_mode = M_IDLE;
               if (d > 0) store(m_cur_n, m_cur_o, d);
            end else if (ln != m_cur_n || lo != m_cur_o) begin
               store(m_cur_n, m_cur_o, (d < 1) ? 1 : d);
               m_cur_n = ln; m_cur_o = lo; m_dur = 0;
            end else if (d == DMAX) begin
               store(m_cur_n, m_cur_o, DMAX);
               m_dur = 0;
            end else begin
               m_dur = d;
            end
         end
         M_LOAD: begin
            if (stop) m_mode = M_IDLE;
            else begin
               m_mode = M_PLAY;
               m_rem = mem_d[m_idx];
            end
         end
         default: begin
            if (ln != 0) begin
               m_note = ln; m_oct = lo;
            end else begin
               m_note = mem_n[m_idx]; m_oct = mem_o[m_idx];
            end
            if (stop) m_mode = M_IDLE;
            else if (tick) begin
               m_rem--;
               if (m_rem == 0) begin
                  m_tcnt = 0;
                  if (m_idx == m_cnt - 1) begin
                     if (loop) begin
                        m_idx = 0; m_mode = M_LOAD;
                     end else begin
                        m_mode = M_IDLE; m_done = 1;
                     end
                  end else begin
                     m_idx++; m_mode = M_LOAD;
                  end
               end
            end
         end
      endcase
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("note", note, m_note);
      check("octave", octave, m_oct);
      check("state", state, m_mode);
      check("count", count, m_cnt);
      check("full", full, m_full);
      check("done", done, m_done);
   endtask

   task automatic set_live(input int n, input int o);
      live_note = 4'(n);
      live_octave = 4'(o);
   endtask

   task automatic record_two();
      set_live(1, 4); rec_start = 1'b1; cycle(); rec_start = 1'b0;
      repeat (12) cycle();
      set_live(3, 4);
      repeat (8) cycle();
      stop = 1'b1; cycle(); stop = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k, kk, en, eo;
      live_note = 0; live_octave = 0; rec_start = 0; play_start = 0; stop = 0; loop = 0;
      s_live_note = 0; s_live_octave = 0; s_rec_start = 0; s_play_start = 0; s_stop = 0;
      s_loop = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      check("rst_note", note, 0);
      check("rst_octave", octave, 0);
      check("rst_state", state, 0);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      check("rst_done", done, 0);

      // Passthrough in idle
      set_live(5, 4); cycle();
      check("pass_note", note, 5);
      check("pass_octave", octave, 4);

      // Record (1,4)x3 ticks, (3,4)x2 ticks, then play back without loop
      record_two();
      check("rec_count", count, 2);
      check("rec_state", state, 0);
      set_live(0, 0); loop = 1'b0;
      for (int e = 0; e < 24; e++) begin
         play_start = (e == 0);
         cycle();
         play_start = 1'b0;
         en = (e < 2 || e > 22) ? 0 : (e <= 14 ? 1 : 3);
         eo = (e < 2 || e > 22) ? 0 : 4;
         check("play_note", note, en);
         check("play_octave", octave, eo);
         check("play_done", done, (e == 22) ? 1 : 0);
         if (e == 0)  check("play_load_state", state, 2);
         if (e == 22) check("play_end_state", state, 0);
      end

      // Overflow on the four-entry instance
      s_live_note = 1; s_live_octave = 1; s_rec_start = 1'b1; cycle(); s_rec_start = 1'b0;
      for (int i = 2; i <= 6; i++) begin
         s_live_note = 4'(i);
         repeat (2) cycle();
         if (i == 4) begin
            check("ovf_count3", s_count, 3);
            check("ovf_nofull", s_full, 0);
         end
         if (i == 5) begin
            check("ovf_full", s_full, 1);
            check("ovf_count", s_count, 4);
            check("ovf_state", s_state, 0);
         end
      end
      check("ovf_count_after", s_count, 4);
      check("ovf_full_after", s_full, 1);

      // Duration saturation: 300 ticks -> 255 + 45
      set_live(2, 5); rec_start = 1'b1; cycle(); rec_start = 1'b0;
      repeat (300 * TICK) cycle();
      stop = 1'b1; cycle(); stop = 1'b0;
      check("sat_count", count, 2);
      set_live(0, 0); play_start = 1'b1; cycle(); play_start = 1'b0;
      k = 0;
      while (!done && k < 1500) begin
         cycle();
         k++;
         if (k == 600) begin
            check("sat_note", note, 2);
            check("sat_octave", octave, 5);
         end
      end
      check("sat_play_len", k, 1 + 255 * TICK + 1 + 45 * TICK);

      // Arbitration with loop playback
      record_two();
      loop = 1'b1; set_live(0, 0);
      play_start = 1'b1; cycle(); play_start = 1'b0;
      repeat (6) cycle();
      set_live(7, 3);
      repeat (6) begin
         cycle();
         check("arb_note", note, 7);
         check("arb_octave", octave, 3);
      end
      set_live(0, 0);
      for (int e = 13; e < 80; e++) begin
         cycle();
         kk = e % 22;
         check("loop_note", note, (kk >= 2 && kk <= 14) ? 1 : 3);
         check("loop_done", done, 0);
      end
      check("loop_active", (state != 2'd0) ? 1 : 0, 1);

      // stop beats rec_start during playback
      stop = 1'b1; rec_start = 1'b1; cycle(); stop = 1'b0; rec_start = 1'b0;
      check("prio_state", state, 0);
      check("prio_count", count, 2);
      loop = 1'b0;

      // Reset in the middle of a recording
      set_live(4, 2); rec_start = 1'b1; cycle(); rec_start = 1'b0;
      repeat (5) cycle();
      set_live(6, 2);
      repeat (3) cycle();
      check("midrec_count", count, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_note", note, 0);
      check("midrst_octave", octave, 0);
      check("midrst_state", state, 0);
      check("midrst_count", count, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // play_start with nothing recorded is ignored
      set_live(0, 0); play_start = 1'b1; cycle(); play_start = 1'b0;
      check("empty_play_state", state, 0);
      cycle();
      check("empty_play_state2", state, 0);

      // Randomized commands and keypad activity
      for (int i = 0; i < 4000; i++) begin
         rec_start  = ($urandom_range(0, 99) < 2);
         play_start = ($urandom_range(0, 99) < 3);
         stop       = ($urandom_range(0, 99) < 1);
         if ($urandom_range(0, 99) < 2) loop = ~loop;
         if ($urandom_range(0, 99) < 10) begin
            live_note   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            live_octave = 4'($urandom_range(0, 7));
         end
         cycle();
      end
      rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Sits between piano_keypad and pitch_generator, and owns the (note, octave) input of the single pitch generator.
- Records live keypad notes with their durations into an on-chip buffer, and plays them back.
- Arbitrates the pitch generator between the live keypad and playback; live input always wins.
- In idle it passes live notes straight through.

Parameters:
- TICK_CYCLES, 1000000: clk cycles per duration tick (10 ms at 100 MHz).
- DEPTH, 64: buffer entries (power of two).
- AW, 6: buffer address width, log2(DEPTH).
- DW, 8: duration field width in ticks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- live_note  in  4  note from piano_keypad; 0 = rest.
- live_octave  in  4  octave from piano_keypad.
- rec_start  in  1  one-cycle pulse: begin recording.
- play_start  in  1  one-cycle pulse: begin playback.
- stop  in  1  one-cycle pulse: end recording or playback.
- loop  in  1  level: playback restarts at entry 0 after the last entry.
- note  out  4  to pitch_generator.
- octave  out  4  to pitch_generator.
- state  out  2  0 IDLE, 1 REC, 2 PLAY_LOAD, 3 PLAY.
- count  out  AW+1  number of valid stored entries.
- full  out  1  sticky; set when recording filled the buffer.
- done  out  1  one-cycle pulse when non-loop playback ends.

Behaviour:
- Reset (async, rst_n=0): note=0, octave=0, state=IDLE, count=0, full=0, done=0; tick counter, duration, address and buffer pointers cleared. Buffer contents are not cleared.
- Outputs are registered: 1-cycle latency from the selected source.
- Tick: counter 0..TICK_CYCLES-1 runs only in REC/PLAY. It clears on entry to REC or PLAY_LOAD. tick is asserted when the counter wraps.
- Command priority when pulses coincide: stop > rec_start > play_start.
- IDLE:
  - note/octave <= live values.
  - rec_start -> REC: count=0, full=0, cur=(live_note, live_octave), dur=0.
  - play_start with count>0 -> PLAY_LOAD at addr 0.
  - play_start with count=0 is ignored.
- REC:
  - Output passes live values through.
  - On tick: dur++. If dur reaches 2^DW-1, write entry (cur, 2^DW-1), count++, dur=0; cur is unchanged.
  - On live change: when (live_note, live_octave) differs from cur, write entry (cur, max(dur,1)), count++, then cur=live, dur=0.
  - Tick and change in the same cycle: the tick increments dur before the write.
  - stop: if dur>0, write the final entry, then -> IDLE.
  - Full: any write that makes count=DEPTH sets full=1 and -> IDLE in the same cycle. Further events are dropped.
  - Entry format: {note[3:0], octave[3:0], dur[DW-1:0]}.
- PLAY_LOAD: one cycle for the synchronous RAM read. Output holds its previous value. Next state PLAY with remaining=dur of the entry read.
- PLAY:
  - Output is live if live_note!=0, otherwise the stored entry (arbitration). Playback timing continues regardless.
  - On tick: remaining--. At 0, addr++ and -> PLAY_LOAD.
  - If addr was count-1: with loop=1, addr=0 -> PLAY_LOAD. With loop=0, -> IDLE with a done pulse.
  - stop -> IDLE immediately; no done pulse.
  - rec_start in PLAY is ignored.
- count saturates at DEPTH. addr never exceeds count-1.
- Reset mid-REC: count=0, so the partial recording is discarded.

Decomposition:
- Package melody_pkg holds:
  - state encoding (IDLE, REC, PLAY_LOAD, PLAY);
  - NOTE_REST=4'd0;
  - the entry field widths and the pack/unpack constants.
- One sub-module, melody_ram: DEPTH x (8+DW) single-port synchronous RAM with write enable and 1-cycle registered read.

Test Plan (TICK_CYCLES=4 on the bench):
- Passthrough: in IDLE set live=(5,4) -> note=5, octave=4 one cycle later.
- Record and play back:
  - Stimulus: rec_start; hold (1,4) for 3 ticks, then (3,4) for 2 ticks; stop.
  - Expect count=2 and entries {1,4,3} and {3,4,2}.
  - play_start with live=0 -> note=1 for 12 cycles, then note=3 for 8 cycles (plus one load cycle each), then done pulse and state=IDLE.
- Overflow: DEPTH=4 bench; record 5 note changes -> full=1, count=4, state=IDLE after the 4th write; 5th change is not stored.
- Saturation: hold (2,5) for 300 ticks with DW=8 -> entries {2,5,255} and {2,5,45}.
- Arbitration and loop: loop=1, play 2 entries, press live (7,3) mid-playback -> output (7,3) while held. After release, output resumes the stored note still on schedule. Playback wraps to entry 0 with no done pulse.
- Priority and edge cases:
  - stop and rec_start in the same cycle during PLAY -> IDLE, count unchanged.
  - play_start with count=0 -> remains IDLE.
  - rst_n low mid-REC -> count=0, outputs 0.
